// File: rtl/alu_dec_encoder_if.sv
// Request/response handshake bundle between a test driver and alu_dec_encoder.
interface alu_dec_encoder_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [1:0] req_mode;
  logic       req_alt;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_pass;
  logic       rsp_illegal;
  logic [2:0] rsp_observed;

  modport master (
    output req_valid, req_op, req_mode, req_alt, rsp_ready,
    input  req_ready, rsp_valid, rsp_pass, rsp_illegal, rsp_observed
  );

  modport slave (
    input  req_valid, req_op, req_mode, req_alt, rsp_ready,
    output req_ready, rsp_valid, rsp_pass, rsp_illegal, rsp_observed
  );
endinterface

// File: rtl/alu_dec_encoder.sv
// Encodes a requested ALUControl value into ALU-decoder input fields, holds them for a
// settle window, samples the decoder result and reports pass/fail with saturating counters.
module alu_dec_encoder #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_dec_encoder_if.slave bus,
  output logic             opb5,
  output logic [2:0]       funct3,
  output logic             funct7b5,
  output logic [1:0]       ALUOp,
  input  logic [2:0]       ALUControl,
  input  logic             clear_cnt,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e           r_state, w_state_d;
  logic [3:0]       r_settle;
  logic [2:0]       r_op;
  logic [1:0]       r_aluop;
  logic [2:0]       r_f3;
  logic             r_f7b5, r_opb5;
  logic             r_pass, r_illegal;
  logic [2:0]       r_observed;
  logic [CNT_W-1:0] r_pass_cnt, r_fail_cnt;

  logic       w_legal, w_op_ok, w_f7b5, w_opb5;
  logic [1:0] w_aluop;
  logic [2:0] w_f3_rtype, w_f3;
  logic       w_accept, w_capture, w_match;

  // Map the requested operation and encoding form onto decoder fields and legality.
  always_comb begin
    w_op_ok    = 1'b1;
    w_f3_rtype = 3'b000;
    w_legal    = 1'b1;
    w_aluop    = 2'b00;
    w_f3       = 3'b000;
    w_f7b5     = 1'b0;
    w_opb5     = 1'b0;
    case (bus.req_op)
      3'b000:  w_f3_rtype = 3'b000;
      3'b001:  w_f3_rtype = 3'b000;
      3'b010:  w_f3_rtype = 3'b111;
      3'b011:  w_f3_rtype = 3'b110;
      3'b101:  w_f3_rtype = 3'b010;
      default: w_op_ok    = 1'b0;
    endcase
    case (bus.req_mode)
      2'b00: begin
        if (bus.req_op == 3'b000)      w_aluop = 2'b00;
        else if (bus.req_op == 3'b001) w_aluop = 2'b01;
        else                           w_legal = 1'b0;
      end
      2'b01: begin
        w_aluop = 2'b10;
        w_opb5  = 1'b1;
        w_f3    = w_f3_rtype;
        w_f7b5  = (bus.req_op == 3'b001);
      end
      2'b10: begin
        // No I-type subtract exists; the immediate bit only matters for add.
        w_aluop = 2'b10;
        w_f3    = w_f3_rtype;
        w_f7b5  = (bus.req_op == 3'b000) & bus.req_alt;
        if (bus.req_op == 3'b001) w_legal = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase
    w_legal = w_legal & w_op_ok;
  end

  assign w_accept  = (r_state == StIdle) && bus.req_valid;
  assign w_capture = (r_state == StDrive) && (r_settle == 4'd1);
  assign w_match   = (ALUControl == r_op);

  // Next-state selection and handshake/decoder outputs.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (bus.req_valid) w_state_d = w_legal ? StDrive : StResp;
      StDrive: if (r_settle == 4'd1) w_state_d = StResp;
      StResp:  if (bus.rsp_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    bus.req_ready    = (r_state == StIdle);
    bus.rsp_valid    = (r_state == StResp);
    bus.rsp_pass     = r_pass;
    bus.rsp_illegal  = r_illegal;
    bus.rsp_observed = r_observed;
    ALUOp    = 2'b00;
    funct3   = 3'b000;
    funct7b5 = 1'b0;
    opb5     = 1'b0;
    if (r_state == StDrive) begin
      ALUOp    = r_aluop;
      funct3   = r_f3;
      funct7b5 = r_f7b5;
      opb5     = r_opb5;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // Transaction fields, settle countdown and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle   <= 4'd0;
      r_op       <= 3'b000;
      r_aluop    <= 2'b00;
      r_f3       <= 3'b000;
      r_f7b5     <= 1'b0;
      r_opb5     <= 1'b0;
      r_pass     <= 1'b0;
      r_illegal  <= 1'b0;
      r_observed <= 3'b000;
    end else if (w_accept) begin
      if (w_legal) begin
        r_settle <= 4'(SETTLE_CYCLES);
        r_op     <= bus.req_op;
        r_aluop  <= w_aluop;
        r_f3     <= w_f3;
        r_f7b5   <= w_f7b5;
        r_opb5   <= w_opb5;
      end else begin
        r_illegal  <= 1'b1;
        r_pass     <= 1'b0;
        r_observed <= 3'b000;
      end
    end else if (r_state == StDrive) begin
      if (w_capture) begin
        r_observed <= ALUControl;
        r_pass     <= w_match;
        r_illegal  <= 1'b0;
      end else begin
        r_settle <= r_settle - 4'd1;
      end
    end else if ((r_state == StResp) && bus.rsp_ready) begin
      r_pass     <= 1'b0;
      r_illegal  <= 1'b0;
      r_observed <= 3'b000;
    end
  end

  // Saturating result counters; a clear in the capture cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else if (clear_cnt) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else if (w_capture) begin
      if (w_match && !(&r_pass_cnt))  r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      if (!w_match && !(&r_fail_cnt)) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
    end
  end

  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_alu_dec_encoder.sv
// Scoreboard bench: dut_a (SETTLE_CYCLES=1, CNT_W=2) runs directed vectors, dut_b
// (SETTLE_CYCLES=4) covers reset during DRIVE and the longer latency.
module tb_alu_dec_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_n_b;
  alu_dec_encoder_if bus_a ();
  alu_dec_encoder_if bus_b ();

  logic        opb5_a, f7b5_a, opb5_b, f7b5_b;
  logic [2:0]  f3_a, f3_b, alu_ctrl_a, alu_ctrl_b;
  logic [1:0]  aluop_a, aluop_b;
  logic        clear_a, clear_b;
  logic [1:0]  pc_a, fc_a;
  logic [15:0] pc_b, fc_b;
  logic        force_en;
  logic [2:0]  force_val;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       pass;
    logic       ill;
    logic [2:0] obs;
    logic [1:0] pc;
    logic [1:0] fc;
  } exp_t;
  exp_t sb_q[$];
  logic [1:0] m_pc = 2'd0;
  logic [1:0] m_fc = 2'd0;

  alu_dec_encoder #(.SETTLE_CYCLES(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave),
    .opb5(opb5_a), .funct3(f3_a), .funct7b5(f7b5_a), .ALUOp(aluop_a),
    .ALUControl(alu_ctrl_a), .clear_cnt(clear_a), .pass_cnt(pc_a), .fail_cnt(fc_a)
  );

  alu_dec_encoder #(.SETTLE_CYCLES(4), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b.slave),
    .opb5(opb5_b), .funct3(f3_b), .funct7b5(f7b5_b), .ALUOp(aluop_b),
    .ALUControl(alu_ctrl_b), .clear_cnt(clear_b), .pass_cnt(pc_b), .fail_cnt(fc_b)
  );

  // Reference single-cycle RISC-V ALU decoder.
  function automatic logic [2:0] dec_model(input logic [1:0] aluop, input logic [2:0] f3,
                                           input logic ob5, input logic f7);
    if (aluop == 2'b00) return 3'b000;
    if (aluop == 2'b01) return 3'b001;
    case (f3)
      3'b000:  return (ob5 & f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b111;
    endcase
  endfunction

  always_comb alu_ctrl_a = force_en ? force_val : dec_model(aluop_a, f3_a, opb5_a, f7b5_a);
  always_comb alu_ctrl_b = dec_model(aluop_b, f3_b, opb5_b, f7b5_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on each accepted response of dut_a.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_a.rsp_valid && bus_a.rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_pass", 32'(bus_a.rsp_pass), 32'(e.pass));
          chk("rsp_illegal", 32'(bus_a.rsp_illegal), 32'(e.ill));
          chk("rsp_observed", 32'(bus_a.rsp_observed), 32'(e.obs));
          chk("pass_cnt", 32'(pc_a), 32'(e.pc));
          chk("fail_cnt", 32'(fc_a), 32'(e.fc));
        end
      end
    end
  end

  // One transaction on dut_a; called #1 after a rising edge with dut_a idle.
  task automatic run(input logic [2:0] op, input logic [1:0] mode, input logic alt,
                     input logic frc, input logic [2:0] fval, input logic hold, input logic clr,
                     input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                     input logic ob5, input logic ill, input logic pass, input logic [2:0] obs);
    exp_t e;
    if (!ill) begin
      if (clr) begin
        m_pc = 2'd0;
        m_fc = 2'd0;
      end else if (pass) begin
        if (m_pc != 2'd3) m_pc = m_pc + 2'd1;
      end else begin
        if (m_fc != 2'd3) m_fc = m_fc + 2'd1;
      end
    end
    e = '{pass: pass, ill: ill, obs: obs, pc: m_pc, fc: m_fc};
    sb_q.push_back(e);
    chk("req_ready_idle", 32'(bus_a.req_ready), 32'd1);
    bus_a.req_op    = op;
    bus_a.req_mode  = mode;
    bus_a.req_alt   = alt;
    bus_a.req_valid = 1'b1;
    force_en        = frc;
    force_val       = fval;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    if (clr) clear_a = 1'b1;
    if (ill) begin
      chk("ill_latency", 32'(bus_a.rsp_valid), 32'd1);
      chk("ill_fields_default", 32'({aluop_a, f3_a, f7b5_a, opb5_a}), 32'd0);
    end else begin
      chk("drive_fields", 32'({aluop_a, f3_a, f7b5_a, opb5_a}), 32'({aluop, f3, f7, ob5}));
      chk("no_early_rsp", 32'(bus_a.rsp_valid), 32'd0);
      @(posedge clk); #1;
      clear_a = 1'b0;
      chk("legal_latency", 32'(bus_a.rsp_valid), 32'd1);
      chk("resp_fields_default", 32'({aluop_a, f3_a, f7b5_a, opb5_a}), 32'd0);
    end
    if (hold) begin
      repeat (5) begin
        @(posedge clk); #1;
        chk("hold_valid", 32'(bus_a.rsp_valid), 32'd1);
        chk("hold_rsp", 32'({bus_a.rsp_pass, bus_a.rsp_illegal, bus_a.rsp_observed}),
            32'({pass, ill, obs}));
      end
    end
    bus_a.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.rsp_ready = 1'b0;
    force_en        = 1'b0;
    chk("idle_after_hs", 32'({bus_a.req_ready, bus_a.rsp_valid}), 32'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; rst_n_b = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_op = 3'b000; bus_a.req_mode = 2'b00;
    bus_a.req_alt = 1'b0; bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_op = 3'b000; bus_b.req_mode = 2'b00;
    bus_b.req_alt = 1'b0; bus_b.rsp_ready = 1'b0;
    clear_a = 1'b0; clear_b = 1'b0; force_en = 1'b0; force_val = 3'b000;
    #2;
    chk("reset_handshake", 32'({bus_a.req_ready, bus_a.rsp_valid}), 32'b10);
    chk("reset_rsp", 32'({bus_a.rsp_pass, bus_a.rsp_illegal, bus_a.rsp_observed}), 32'd0);
    chk("reset_counters", 32'({pc_a, fc_a}), 32'd0);
    chk("reset_fields", 32'({aluop_a, f3_a, f7b5_a, opb5_a}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    //  op      mode   alt  frc  fval    hold clr  aluop  f3      f7   ob5  ill  pass obs
    run(3'b001, 2'b01, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001);
    run(3'b000, 2'b10, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    run(3'b001, 2'b10, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    run(3'b010, 2'b01, 1'b0, 1'b1, 3'b011, 1'b1, 1'b0, 2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 3'b011);
    run(3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    run(3'b001, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
    run(3'b101, 2'b01, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b10, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 3'b101);
    run(3'b011, 2'b10, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b10, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011);
    run(3'b010, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    run(3'b100, 2'b01, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    run(3'b000, 2'b11, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    run(3'b111, 2'b10, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    run(3'b000, 2'b10, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    run(3'b000, 2'b01, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
    run(3'b000, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    run(3'b010, 2'b10, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b10, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010);

    // dut_b: reset while in DRIVE discards the transaction.
    rst_n_b = 1'b1;
    bus_b.req_op = 3'b001; bus_b.req_mode = 2'b01; bus_b.req_valid = 1'b1;
    @(posedge clk); #1;
    bus_b.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("b_drive_fields", 32'({aluop_b, f3_b, f7b5_b, opb5_b}), 32'b10_000_1_1);
    #2 rst_n_b = 1'b0;
    #1;
    chk("b_reset_handshake", 32'({bus_b.req_ready, bus_b.rsp_valid}), 32'b10);
    chk("b_reset_fields", 32'({aluop_b, f3_b, f7b5_b, opb5_b}), 32'd0);
    chk("b_reset_counters", 32'({pc_b, fc_b}), 32'd0);
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus_b.rsp_valid) n++;
    end
    chk("b_no_rsp_after_reset", 32'(n), 32'd0);
    chk("b_counters_after_reset", 32'({pc_b, fc_b}), 32'd0);

    // dut_b: full transaction with SETTLE_CYCLES=4.
    bus_b.req_op = 3'b000; bus_b.req_mode = 2'b01; bus_b.req_valid = 1'b1;
    @(posedge clk); #1;
    bus_b.req_valid = 1'b0;
    n = 0;
    while (!bus_b.rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b_latency", 32'(n), 32'd4);
    chk("b_rsp", 32'({bus_b.rsp_pass, bus_b.rsp_illegal, bus_b.rsp_observed}), 32'b1_0_000);
    chk("b_pass_cnt", 32'(pc_b), 32'd1);
    bus_b.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus_b.rsp_ready = 1'b0;
    chk("b_idle_after_hs", 32'({bus_b.req_ready, bus_b.rsp_valid}), 32'b10);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_dec_encoder.md
ALU_DEC_ENCODER -- requirements
Module: alu_dec_encoder

Interface
REQ-001 Parameter SETTLE_CYCLES, 1, number of cycles the decoder inputs are held before ALUControl is sampled (legal range 1..15).
REQ-002 Parameter CNT_W, 16, width of pass/fail counters.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_op  input  3  requested ALUControl: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-009 req_mode  input  2  encoding form: 00 direct (ALUOp 00/01), 01 R-type, 10 I-type, 11 reserved.
REQ-010 req_alt  input  1  I-type add only: drive funct7b5=1 (immediate bit) instead of 0.
REQ-011 opb5, funct3[2:0], funct7b5, ALUOp[1:0]  output  1/3/1/2  fields driven to the ALU decoder.
REQ-012 ALUControl  input  3  decoder result.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  response consumed.
REQ-015 rsp_pass, rsp_illegal  output  1 each  sampled result equals req_op; request not encodable.
REQ-016 rsp_observed  output  3  ALUControl as sampled.
REQ-017 pass_cnt, fail_cnt  output  CNT_W each  saturating result counters.
REQ-018 clear_cnt  input  1  synchronous counter clear.

Function
REQ-019 FSM states IDLE, DRIVE, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-020 IDLE: req_valid=1 with legal request -> register fields, go DRIVE, load settle counter with SETTLE_CYCLES.
REQ-021 IDLE: req_valid=1 with illegal request -> go RESP directly; rsp_illegal=1, rsp_pass=0, rsp_observed=000, counters unchanged, decoder outputs stay at default.
REQ-022 Illegal: req_mode=11; req_op in {100,110,111}; mode 00 with op not add/sub; mode 10 with op sub.
REQ-023 Mode 00: ALUOp=00 (add) or 01 (sub); funct3=000, funct7b5=0, opb5=0.
REQ-024 Mode 01: ALUOp=10, opb5=1; add f3=000 f7b5=0; sub f3=000 f7b5=1; slt 010; or 110; and 111; f7b5=0 except sub.
REQ-025 Mode 10: ALUOp=10, opb5=0, funct3 as mode 01; funct7b5=req_alt for add, else 0.
REQ-026 DRIVE: fields held constant for exactly SETTLE_CYCLES cycles; ALUControl captured into rsp_observed at the rising edge ending the last DRIVE cycle; same edge enters RESP.
REQ-027 Latency: legal accept at edge T -> rsp_valid=1 from T+SETTLE_CYCLES+1; illegal accept at T -> rsp_valid=1 from T+1.
REQ-028 rsp_pass=(rsp_observed==registered req_op), evaluated at capture edge.
REQ-029 At capture edge: pass_cnt+1 if pass else fail_cnt+1; saturate at all-ones (no wrap).
REQ-030 RESP: rsp_* held stable until rsp_valid&rsp_ready; that edge returns to IDLE; no new request accepted in same cycle.
REQ-031 Outside DRIVE, decoder outputs = default ALUOp=00, funct3=000, funct7b5=0, opb5=0.
REQ-032 clear_cnt zeroes both counters next edge; clear and increment in same cycle -> clear wins (result 0).
REQ-033 req_* ignored outside IDLE; rsp_ready ignored outside RESP.

Reset
REQ-034 rst_n=0 asynchronously: state IDLE, req_ready=1, rsp_valid=0, rsp_pass=0, rsp_illegal=0, rsp_observed=000, counters 0, decoder outputs default.
REQ-035 Reset mid-DRIVE or mid-RESP discards pending transaction; no counter update.
REQ-036 First request accepted on first rising edge after rst_n deasserts.

Verification
REQ-037 SETTLE_CYCLES=1, mode 01 op 001, correct decoder -> fields 10/000/1/1 for one cycle, rsp_valid at T+2, rsp_pass=1, rsp_observed=001, pass_cnt=1.
REQ-038 Mode 10 op 000 req_alt=1 -> opb5=0, funct7b5=1, ALUOp=10; correct decoder returns 000, rsp_pass=1.
REQ-039 Mode 10 op 001 -> rsp_illegal=1 at T+1, counters unchanged, decoder outputs default throughout.
REQ-040 Decoder stub forcing 011 on mode 01 op 010 -> rsp_pass=0, rsp_observed=011, fail_cnt+1; rsp_ready held 0 five cycles -> outputs stable.
REQ-041 CNT_W=2, four passing requests -> pass_cnt stays 11; clear_cnt with simultaneous pass -> 00.
REQ-042 rst_n low during DRIVE (SETTLE_CYCLES=4) -> immediate IDLE, defaults, counters 0, no response.
